// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART receive deframer and its consumer.
// The producer drives the head entry and valid; the consumer drives ready.
interface uart_rx_deframer_if;
  logic [7:0] rx_byte;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_byte, rx_parity_err, rx_frame_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_byte, rx_parity_err, rx_frame_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8E1 frames sampled at bit centre, parity/stop checks,
// FWFT FIFO of {frame_err, parity_err, byte} with a sticky overrun flag.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_serial,
  uart_rx_deframer_if.master      rx_bus,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = (HALF > 0) ? CW'(HALF - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          perr, perr_n;
  logic          push;
  logic          ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      perr  <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    perr_n  = perr;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_serial) begin
          // At one or two clocks per bit there is no room to recheck the start bit
          if (HALF == 0) begin
            state_n = DATA;
            cnt_n   = RELOAD;
            idx_n   = '0;
          end else begin
            state_n = START;
            cnt_n   = HALF_M1;
          end
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_serial) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          cnt_n   = RELOAD;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n[idx] = rx_serial;
          cnt_n        = RELOAD;
          idx_n        = idx + 1'b1;
          if (idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          perr_n  = (^shreg) ^ rx_serial;
          cnt_n   = RELOAD;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          ferr    = ~rx_serial;
          push    = 1'b1;
          state_n = ferr ? BRK : IDLE;
        end
      end
      BRK: begin
        if (rx_serial) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          valid, full, pop, wr_en, drop;
  logic [9:0]    head;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = valid & rx_bus.rx_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ferr, perr, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign head                 = mem[rd_ptr];
  assign rx_bus.rx_valid      = valid;
  assign rx_bus.rx_byte       = valid ? head[7:0] : '0;
  assign rx_bus.rx_parity_err = valid & head[8];
  assign rx_bus.rx_frame_err  = valid & head[9];
  assign fifo_count           = count;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: one instance at 1 clock/bit, one at 8 clocks/bit,
// expected entries queued as frames are driven and compared as they are consumed.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1, rx8;
  logic       ov1, ov8;
  logic       clr1, clr8;
  logic [2:0] cnt1, cnt8;

  always #5 clk = ~clk;

  uart_rx_deframer_if bus1 ();
  uart_rx_deframer_if bus8 ();

  uart_rx_deframer #(.CLKS_PER_BIT(1), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rx_serial(rx1), .rx_bus(bus1.master),
    .overrun(ov1), .overrun_clr(clr1), .fifo_count(cnt1)
  );

  uart_rx_deframer #(.CLKS_PER_BIT(8), .DEPTH(4)) u8 (
    .clk(clk), .rst(rst), .rx_serial(rx8), .rx_bus(bus8.master),
    .overrun(ov8), .overrun_clr(clr8), .fifo_count(cnt8)
  );

  typedef struct {
    logic [7:0]  d;
    logic        pflip;
    logic        sbit;
    int unsigned hold_low;
    int unsigned gap;
    logic [7:0]  eb;
    logic        ep;
    logic        ef;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       p;
    logic       f;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus1.rx_valid === 1'b1 && bus1.rx_ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL dut1 unexpected entry: got byte 0x%0h expected none", bus1.rx_byte);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 byte", 32'(bus1.rx_byte), 32'(e1.b));
        chk("dut1 parity_err", 32'(bus1.rx_parity_err), 32'(e1.p));
        chk("dut1 frame_err", 32'(bus1.rx_frame_err), 32'(e1.f));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus8.rx_valid === 1'b1 && bus8.rx_ready === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        $display("FAIL dut8 unexpected entry: got byte 0x%0h expected none", bus8.rx_byte);
      end else begin
        e8 = q8.pop_front();
        chk("dut8 byte", 32'(bus8.rx_byte), 32'(e8.b));
        chk("dut8 parity_err", 32'(bus8.rx_parity_err), 32'(e8.p));
        chk("dut8 frame_err", 32'(bus8.rx_frame_err), 32'(e8.f));
      end
    end
  end

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic pbit, input logic sbit);
    return {sbit, pbit, d, 1'b0};
  endfunction

  task automatic set_line(input int unsigned dut, input logic b);
    if (dut == 1) rx1 = b;
    else          rx8 = b;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int unsigned dut, input logic [10:0] f,
                           input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) begin
      set_line(dut, f[i]);
      tick((dut == 1) ? 1 : 8);
    end
  endtask

  task automatic wait_drain(input int unsigned dut, input int unsigned budget);
    int unsigned n = 0;
    while (((dut == 1) ? q1.size() : q8.size()) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (((dut == 1) ? q1.size() : q8.size()) != 0) begin
      checks++;
      $display("FAIL dut%0d drain timeout: got %0d entries outstanding expected 0", dut,
               (dut == 1) ? q1.size() : q8.size());
      if (dut == 1) q1.delete();
      else          q8.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [10:0] f;
    logic [7:0]  d;

    vecs[0] = '{d:8'h01, pflip:1'b1, sbit:1'b1, hold_low:0, gap:1, eb:8'h01, ep:1'b1, ef:1'b0};
    vecs[1] = '{d:8'h3C, pflip:1'b0, sbit:1'b0, hold_low:5, gap:1, eb:8'h3C, ep:1'b0, ef:1'b1};
    vecs[2] = '{d:8'hFF, pflip:1'b0, sbit:1'b1, hold_low:0, gap:0, eb:8'hFF, ep:1'b0, ef:1'b0};
    vecs[3] = '{d:8'h00, pflip:1'b0, sbit:1'b1, hold_low:0, gap:0, eb:8'h00, ep:1'b0, ef:1'b0};
    vecs[4] = '{d:8'h80, pflip:1'b1, sbit:1'b1, hold_low:0, gap:2, eb:8'h80, ep:1'b1, ef:1'b0};
    vecs[5] = '{d:8'h7E, pflip:1'b0, sbit:1'b1, hold_low:0, gap:1, eb:8'h7E, ep:1'b0, ef:1'b0};

    rst = 1'b1;
    rx1 = 1'b1;
    rx8 = 1'b1;
    clr1 = 1'b0;
    clr8 = 1'b0;
    bus1.rx_ready = 1'b1;
    bus8.rx_ready = 1'b1;
    tick(2);

    chk("reset valid", 32'(bus1.rx_valid), 32'd0);
    chk("reset byte", 32'(bus1.rx_byte), 32'd0);
    chk("reset perr", 32'(bus1.rx_parity_err), 32'd0);
    chk("reset ferr", 32'(bus1.rx_frame_err), 32'd0);
    chk("reset count", 32'(cnt1), 32'd0);
    chk("reset overrun", 32'(ov1), 32'd0);
    chk("reset dut8 valid", 32'(bus8.rx_valid), 32'd0);
    rst = 1'b0;
    tick(2);

    // Latency: valid exactly one cycle after the stop bit is sampled
    f = mkframe(8'hA5, 1'b0, 1'b1);
    q1.push_back('{b:8'hA5, p:1'b0, f:1'b0});
    send_bits(1, f, 0, 9);
    chk("latency not early", 32'(bus1.rx_valid), 32'd0);
    send_bits(1, f, 10, 10);
    chk("latency valid", 32'(bus1.rx_valid), 32'd1);
    chk("latency byte", 32'(bus1.rx_byte), 32'hA5);
    chk("latency count", 32'(cnt1), 32'd1);
    tick(1);
    chk("valid one cycle", 32'(bus1.rx_valid), 32'd0);
    tick(2);

    for (int i = 0; i < 6; i++) begin
      q1.push_back('{b:vecs[i].eb, p:vecs[i].ep, f:vecs[i].ef});
      f = mkframe(vecs[i].d, (^vecs[i].d) ^ vecs[i].pflip, vecs[i].sbit);
      send_bits(1, f, 0, 10);
      if (vecs[i].hold_low != 0) begin
        set_line(1, 1'b0);
        tick(vecs[i].hold_low);
      end
      set_line(1, 1'b1);
      if (vecs[i].gap != 0) tick(vecs[i].gap);
    end
    wait_drain(1, 50);
    tick(20);
    chk("table no extra entry", 32'(bus1.rx_valid), 32'd0);

    // Overrun: five frames into a four-deep FIFO with the consumer stalled
    bus1.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < 4) q1.push_back('{b:d, p:1'b0, f:1'b0});
      send_bits(1, mkframe(d, ^d, 1'b1), 0, 10);
      set_line(1, 1'b1);
      tick(1);
    end
    tick(2);
    chk("full count", 32'(cnt1), 32'd4);
    chk("overrun set", 32'(ov1), 32'd1);
    chk("full head", 32'(bus1.rx_byte), 32'h11);
    bus1.rx_ready = 1'b1;
    wait_drain(1, 20);
    tick(2);
    chk("drained valid", 32'(bus1.rx_valid), 32'd0);
    chk("drained count", 32'(cnt1), 32'd0);
    chk("overrun sticky", 32'(ov1), 32'd1);
    clr1 = 1'b1;
    tick(1);
    clr1 = 1'b0;
    chk("overrun cleared", 32'(ov1), 32'd0);

    // Reset in the middle of the data phase
    send_bits(1, mkframe(8'h96, 1'b0, 1'b1), 0, 4);
    rst = 1'b1;
    rx1 = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midreset valid", 32'(bus1.rx_valid), 32'd0);
    chk("midreset count", 32'(cnt1), 32'd0);
    tick(15);
    chk("midreset no entry", 32'(bus1.rx_valid), 32'd0);
    q1.push_back('{b:8'hC3, p:1'b0, f:1'b0});
    send_bits(1, mkframe(8'hC3, 1'b0, 1'b1), 0, 10);
    set_line(1, 1'b1);
    wait_drain(1, 20);

    // Eight clocks per bit: single-cycle glitch, then a real frame
    rx8 = 1'b0;
    tick(1);
    rx8 = 1'b1;
    tick(30);
    chk("glitch no entry", 32'(bus8.rx_valid), 32'd0);
    chk("glitch count", 32'(cnt8), 32'd0);
    q8.push_back('{b:8'h5A, p:1'b0, f:1'b0});
    send_bits(8, mkframe(8'h5A, 1'b0, 1'b1), 0, 10);
    set_line(8, 1'b1);
    wait_drain(8, 100);
    tick(20);
    chk("dut8 empty after frame", 32'(cnt8), 32'd0);
    chk("dut8 overrun", 32'(ov8), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial receive stage that consumes the 1-start / 8-data (LSB first) / 1-even-parity / 1-stop frame produced by the team's UART transmitter.
- Samples the line at bit centre.
- Checks parity and stop bit.
- Queues each received byte, with its error flags, in a small first-word-fall-through (FWFT) FIFO.
- Presents bytes to downstream logic over a valid/ready handshake.
- Replaces the bare receive path where error reporting and backpressure are required.

Parameters:
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); 1 matches the one-bit-per-clock transmitter.
DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rx_serial  input  1  serial line, idles high.
rx_byte  output  8  FIFO head data; 0 when empty.
rx_parity_err  output  1  head entry parity error flag; 0 when empty.
rx_frame_err  output  1  head entry stop-bit error flag; 0 when empty.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer accepts head when rx_valid & rx_ready.
overrun  output  1  sticky: a completed frame was dropped because the FIFO was full.
overrun_clr  input  1  single-cycle pulse clears overrun.
fifo_count  output  $clog2(DEPTH)+1  entries held.

Behaviour:
Reset (one clk with rst=1):
- State IDLE, FIFO empty, partial frame discarded.
- All outputs 0.
- Reset mid-frame never produces an entry.

Timing constants:
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Bit counter cnt is $clog2(CLKS_PER_BIT)+1 bits wide.

State machine:
- IDLE:
  - rx_serial=0 and HALF=0 -> DATA, cnt=CLKS_PER_BIT-1, bit index 0.
  - rx_serial=0 and HALF>0 -> START, cnt=HALF-1.
- START: decrement cnt. At cnt=0, resample the line:
  - 0 -> DATA, cnt=CLKS_PER_BIT-1.
  - 1 -> IDLE (glitch rejected, nothing queued).
- DATA: decrement cnt. At cnt=0:
  - Shift rx_serial into shreg[idx]; reload cnt.
  - After idx 7 -> PARITY.
  - With CLKS_PER_BIT=1, cnt stays 0 and one bit is sampled per cycle.
- PARITY: at cnt=0, perr = ^shreg ^ rx_serial (even parity: a 1-bit when the data has odd popcount). Reload cnt -> STOP.
- STOP: at cnt=0, ferr = ~rx_serial.
  - Push {ferr, perr, shreg} to the FIFO.
  - ferr=0 -> IDLE; ferr=1 -> BREAK.
- BREAK: remain until rx_serial=1, then IDLE. A held-low line produces no further frames.

Latency and back-to-back frames:
- CLKS_PER_BIT=1: start seen at cycle t -> data t+1..t+8, parity t+9, stop t+10, rx_valid high at t+11.
- A new start may be detected in the cycle after STOP.

FIFO (FWFT):
- rx_valid = (count != 0).
- Pop on rx_valid & rx_ready.
- Push and pop in the same cycle: count unchanged, legal even when full.
- Push while full with no pop: frame dropped, FIFO contents and count unchanged, overrun <= 1.
- Pop while empty: ignored.
- Pointers wrap modulo DEPTH.

overrun:
- Cleared by rst or overrun_clr.
- Set has priority over clear in the same cycle.

Test Plan:
- CLKS_PER_BIT=1, rx_ready=1, line 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) starting cycle t -> rx_valid at t+11 for one cycle, rx_byte=0xA5, rx_parity_err=0, rx_frame_err=0.
- Frame 0x01 with parity bit 0 -> rx_byte=0x01, rx_parity_err=1, rx_frame_err=0.
- Frame 0x3C, correct parity, stop bit 0, line held low 5 more cycles then high -> one entry, rx_frame_err=1; no second entry created by the held-low period.
- DEPTH=4, rx_ready=0, five frames 0x11,0x22,0x33,0x44,0x55:
  - fifo_count=4, overrun=1.
  - Then rx_ready=1 pops 0x11,0x22,0x33,0x44 in order, then rx_valid=0.
  - overrun_clr pulse -> overrun=0.
- CLKS_PER_BIT=8:
  - Single-cycle low glitch on the idle line -> no entry.
  - Then frame 0x5A at 8 clocks/bit -> rx_byte=0x5A, no errors.
- rst asserted in the middle of a frame's DATA phase -> no entry; the next full frame 0xC3 is received correctly.
